generic_reserv_station: RTL and testbench

- Parametrised reservation station for any EX functional unit (ALU, branch, mem address).
- Replaces the fixed per-unit single-purpose stations.
- Holds DEPTH dispatched instructions and snoops BCAST_NUM result-broadcast channels for pending operand tags.
- Issues the oldest fully-ready entry through a registered valid/ready output stage to the unit datapath.

---
 rtl/generic_reserv_station_if.sv | 51 +++++
 rtl/generic_reserv_station.sv | 216 +++++++++++++++++++++
 tb/tb_generic_reserv_station.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/generic_reserv_station_if.sv
// Dispatch, result-broadcast and issue bundle for generic_reserv_station.
// Master drives dispatch, flush, broadcasts and out_ready. Slave returns status and the issued op.
// Carries no state and adds no latency; full and count come straight from the station's registers.
interface generic_reserv_station_if #(
  parameter int DEPTH     = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4,
  parameter int OP_W      = 6,
  parameter int BCAST_NUM = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // squash and dispatch side
  logic                      flush;
  logic                      in_ce;
  logic [TAG_W-1:0]          in_target;
  logic [OP_W-1:0]           in_op;
  logic [DATA_W-1:0]         in_val1;
  logic [DATA_W-1:0]         in_val2;
  logic [TAG_W-1:0]          in_tag1;
  logic [TAG_W-1:0]          in_tag2;

  // result broadcast channels, channel 0 in the LSBs
  logic [BCAST_NUM-1:0]        bc_valid;
  logic [BCAST_NUM*TAG_W-1:0]  bc_tag;
  logic [BCAST_NUM*DATA_W-1:0] bc_data;

  // occupancy status
  logic                      full;
  logic [CNT_W-1:0]          count;

  // issue side
  logic                      out_ready;
  logic                      out_valid;
  logic [TAG_W-1:0]          out_target;
  logic [OP_W-1:0]           out_op;
  logic [DATA_W-1:0]         out_val1;
  logic [DATA_W-1:0]         out_val2;

  modport master (
    output flush, in_ce, in_target, in_op, in_val1, in_val2, in_tag1, in_tag2,
    output bc_valid, bc_tag, bc_data, out_ready,
    input  full, count, out_valid, out_target, out_op, out_val1, out_val2
  );

  modport slave (
    input  flush, in_ce, in_target, in_op, in_val1, in_val2, in_tag1, in_tag2,
    input  bc_valid, bc_tag, bc_data, out_ready,
    output full, count, out_valid, out_target, out_op, out_val1, out_val2
  );
endinterface

// File: rtl/generic_reserv_station.sv
// Reservation station: holds DEPTH ops, snoops result broadcasts for operand tags, issues the oldest ready op.
// Latency: a ready dispatch in cycle c shows out_valid in cycle c+2; a broadcast makes an entry issuable one cycle later.
// Backpressure: out_valid && !out_ready freezes the output register and no entry leaves; dispatch is dropped while full.
module generic_reserv_station #(
  parameter int               DEPTH       = 4,
  parameter int               DATA_W      = 32,
  parameter int               TAG_W       = 4,
  parameter int               OP_W        = 6,
  parameter int               BCAST_NUM   = 2,
  parameter logic [TAG_W-1:0] TAG_INVALID = '0
) (
  input logic                     clk,
  input logic                     rst,
  generic_reserv_station_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  target;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag1;
    logic [TAG_W-1:0]  tag2;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
  } entry_t;

  // local views of the bundle
  logic                        flush;
  logic                        in_ce;
  logic [TAG_W-1:0]            in_target;
  logic [OP_W-1:0]             in_op;
  logic [DATA_W-1:0]           in_val1;
  logic [DATA_W-1:0]           in_val2;
  logic [TAG_W-1:0]            in_tag1;
  logic [TAG_W-1:0]            in_tag2;
  logic [BCAST_NUM-1:0]        bc_valid;
  logic [BCAST_NUM*TAG_W-1:0]  bc_tag;
  logic [BCAST_NUM*DATA_W-1:0] bc_data;
  logic                        out_ready;

  assign flush     = bus.flush;
  assign in_ce     = bus.in_ce;
  assign in_target = bus.in_target;
  assign in_op     = bus.in_op;
  assign in_val1   = bus.in_val1;
  assign in_val2   = bus.in_val2;
  assign in_tag1   = bus.in_tag1;
  assign in_tag2   = bus.in_tag2;
  assign bc_valid  = bus.bc_valid;
  assign bc_tag    = bus.bc_tag;
  assign bc_data   = bus.bc_data;
  assign out_ready = bus.out_ready;

  // station state; older[j][i] set means slot j was allocated before slot i
  entry_t            ent   [DEPTH];
  logic [DEPTH-1:0]  older [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic              full_q;
  logic              out_valid_q;
  logic [TAG_W-1:0]  out_target_q;
  logic [OP_W-1:0]   out_op_q;
  logic [DATA_W-1:0] out_val1_q;
  logic [DATA_W-1:0] out_val2_q;

  assign bus.full       = full_q;
  assign bus.count      = count_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_target = out_target_q;
  assign bus.out_op     = out_op_q;
  assign bus.out_val1   = out_val1_q;
  assign bus.out_val2   = out_val2_q;

  // Returns {hit, data} for a pending tag; scanning from the top lets the lowest channel win.
  // A TAG_INVALID operand is already ready and never matches.
  function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0] t);
    logic [DATA_W:0] r;
    r = '0;
    for (int k = BCAST_NUM - 1; k >= 0; k--) begin
      if (bc_valid[k] && (bc_tag[k*TAG_W +: TAG_W] == t) && (t != TAG_INVALID)) begin
        r = {1'b1, bc_data[k*DATA_W +: DATA_W]};
      end
    end
    return r;
  endfunction

  logic [DATA_W:0]  wk1 [DEPTH];
  logic [DATA_W:0]  wk2 [DEPTH];
  logic [DEPTH-1:0] ready;

  // Per-entry broadcast match and readiness from registered tags
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wk1[i]   = snoop(ent[i].tag1);
      wk2[i]   = snoop(ent[i].tag2);
      ready[i] = ent[i].vld && (ent[i].tag1 == TAG_INVALID) && (ent[i].tag2 == TAG_INVALID);
    end
  end

  logic [DEPTH-1:0] is_oldest;
  logic             sel_vld;
  logic [IDX_W-1:0] sel_idx;

  // Oldest ready entry: ready with no older ready entry, independent of slot index
  always_comb begin
    is_oldest = '0;
    sel_vld   = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      is_oldest[i] = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && ready[j] && older[j][i]) begin
          is_oldest[i] = 1'b0;
        end
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (is_oldest[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  logic [IDX_W-1:0] alloc_idx;

  // Lowest-index free slot, judged on registered valid bits so a slot freed this cycle is not reused
  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent[i].vld) begin
        alloc_idx = IDX_W'(i);
      end
    end
  end

  logic             accept;
  logic             issue;
  logic [CNT_W-1:0] cnt_nxt;
  logic [DATA_W:0]  byp1;
  logic [DATA_W:0]  byp2;
  entry_t           new_ent;

  assign accept  = in_ce && (in_target != TAG_INVALID) && !full_q;
  assign issue   = sel_vld && (!out_valid_q || out_ready);
  assign cnt_nxt = count_q + CNT_W'(accept) - CNT_W'(issue);

  // New entry, with operands captured directly from a broadcast seen in the dispatch cycle
  always_comb begin
    byp1           = snoop(in_tag1);
    byp2           = snoop(in_tag2);
    new_ent        = '0;
    new_ent.vld    = 1'b1;
    new_ent.target = in_target;
    new_ent.op     = in_op;
    new_ent.val1   = byp1[DATA_W] ? byp1[DATA_W-1:0] : in_val1;
    new_ent.tag1   = byp1[DATA_W] ? TAG_INVALID : in_tag1;
    new_ent.val2   = byp2[DATA_W] ? byp2[DATA_W-1:0] : in_val2;
    new_ent.tag2   = byp2[DATA_W] ? TAG_INVALID : in_tag2;
  end

  // Entry storage, age matrix, occupancy and the registered issue stage
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i]   <= '0;
        older[i] <= '0;
      end
      count_q      <= '0;
      full_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_target_q <= TAG_INVALID;
      out_op_q     <= '0;
      out_val1_q   <= '0;
      out_val2_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue && (sel_idx == IDX_W'(i))) begin
          ent[i].vld <= 1'b0;
        end else if (ent[i].vld) begin
          if (wk1[i][DATA_W]) begin
            ent[i].val1 <= wk1[i][DATA_W-1:0];
            ent[i].tag1 <= TAG_INVALID;
          end
          if (wk2[i][DATA_W]) begin
            ent[i].val2 <= wk2[i][DATA_W-1:0];
            ent[i].tag2 <= TAG_INVALID;
          end
        end
      end

      // The newcomer is younger than every entry still held; its own row is cleared
      if (accept) begin
        ent[alloc_idx] <= new_ent;
        for (int j = 0; j < DEPTH; j++) begin
          older[j][alloc_idx] <= ent[j].vld;
          older[alloc_idx][j] <= 1'b0;
        end
      end

      count_q <= cnt_nxt;
      full_q  <= (cnt_nxt == CNT_W'(DEPTH));

      if (issue) begin
        out_valid_q  <= 1'b1;
        out_target_q <= ent[sel_idx].target;
        out_op_q     <= ent[sel_idx].op;
        out_val1_q   <= ent[sel_idx].val1;
        out_val2_q   <= ent[sel_idx].val2;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_generic_reserv_station.sv
// Directed bench for generic_reserv_station: one table row per clock cycle plus reset and flush sequences.
// Each row drives inputs before an edge; expectations are the registered outputs just after that edge.
// Opcodes are driven as {2'b10, target} so the issued opcode is checkable against the expected target.
module tb_generic_reserv_station;
  localparam int DEPTH     = 4;
  localparam int DATA_W    = 32;
  localparam int TAG_W     = 4;
  localparam int OP_W      = 6;
  localparam int BCAST_NUM = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  generic_reserv_station_if #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .BCAST_NUM(BCAST_NUM)
  ) bus ();

  generic_reserv_station #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .BCAST_NUM(BCAST_NUM),
    .TAG_INVALID('0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int fl; int ce; int tgt; int t1; int t2; int v1; int v2;
    int bcv; int bt0; int bd0; int bt1; int bd1; int rdy;
    int ef; int ec; int ev; int et; int e1; int e2;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int fl, ce, tgt, t1, t2, v1, v2, bcv, bt0, bd0, bt1, bd1, rdy,
                     input int ef, ec, ev, et, e1, e2);
    vec_t v;
    v = '{fl, ce, tgt, t1, t2, v1, v2, bcv, bt0, bd0, bt1, bd1, rdy, ef, ec, ev, et, e1, e2};
    vecs.push_back(v);
  endtask

  task automatic idle(input int rdy, ef, ec, ev, et, e1, e2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, ef, ec, ev, et, e1, e2);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    logic [31:0] t;
    t = v.tgt;
    bus.flush     = v.fl[0];
    bus.in_ce     = v.ce[0];
    bus.in_target = t[TAG_W-1:0];
    bus.in_op     = {2'b10, t[TAG_W-1:0]};
    bus.in_tag1   = v.t1[TAG_W-1:0];
    bus.in_tag2   = v.t2[TAG_W-1:0];
    bus.in_val1   = v.v1;
    bus.in_val2   = v.v2;
    bus.bc_valid  = v.bcv[BCAST_NUM-1:0];
    bus.bc_tag    = {v.bt1[TAG_W-1:0], v.bt0[TAG_W-1:0]};
    bus.bc_data   = {v.bd1, v.bd0};
    bus.out_ready = v.rdy[0];
  endtask

  initial begin
    vec_t        v;
    logic [31:0] et;
    checks = 0;
    errors = 0;

    // Reset held with a dispatch present: reset must win
    v = '{0, 1, 3, 0, 0, 5, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    drive(v);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset count", 32'(bus.count), 0);
    chk("reset full", 32'(bus.full), 0);
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset out_target", 32'(bus.out_target), 0);
    chk("reset out_op", 32'(bus.out_op), 0);
    chk("reset out_val1", bus.out_val1, 0);
    chk("reset out_val2", bus.out_val2, 0);

    // Ready dispatch issues at c+2; a valid broadcast of TAG_INVALID must not touch val1
    add(0, 1, 3, 0, 0, 5, 7, 1, 0, 'hBAD, 0, 0, 1,          0, 1, 0, 0, 0, 0);
    idle(1,                                                  0, 0, 1, 3, 5, 7);
    idle(1,                                                  0, 0, 0, 0, 0, 0);
    // Pending tag1=6 woken by channel 1 only (channel 0 carries tag 6 but is not valid)
    add(0, 1, 2, 6, 0, 0, 'h22, 0, 0, 0, 0, 0, 1,           0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 'hBAD, 0, 0, 1,          0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 2, 6, 'hDEAD, 6, 'hAB, 1,      0, 1, 0, 0, 0, 0);
    idle(1,                                                  0, 0, 1, 2, 'hAB, 'h22);
    idle(1,                                                  0, 0, 0, 0, 0, 0);
    // Dispatch bypass, both channels carry tag 9: channel 0 wins
    add(0, 1, 7, 9, 9, 0, 0, 3, 9, 'h11, 9, 'h99, 1,        0, 1, 0, 0, 0, 0);
    idle(1,                                                  0, 0, 1, 7, 'h11, 'h11);
    idle(1,                                                  0, 0, 0, 0, 0, 0);
    // Park target 6 in the stalled output stage, fill all four slots, try target 5 while full
    add(0, 1, 6, 0, 0, 'h60, 'h61, 0, 0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0);
    idle(0,                                                  0, 0, 1, 6, 'h60, 'h61);
    add(0, 1, 1, 11, 0, 0, 'h101, 0, 0, 0, 0, 0, 0,         0, 1, 1, 6, 'h60, 'h61);
    add(0, 1, 2, 12, 0, 0, 'h102, 0, 0, 0, 0, 0, 0,         0, 2, 1, 6, 'h60, 'h61);
    add(0, 1, 3, 13, 13, 0, 0, 0, 0, 0, 0, 0, 0,            0, 3, 1, 6, 'h60, 'h61);
    add(0, 1, 4, 14, 13, 0, 0, 0, 0, 0, 0, 0, 0,            1, 4, 1, 6, 'h60, 'h61);
    add(0, 1, 5, 0, 0, 'h55, 'h55, 0, 0, 0, 0, 0, 0,        1, 4, 1, 6, 'h60, 'h61);
    // Wake in reverse slot order; target 4 wakes both operands from two channels, target 3 from one
    add(0, 0, 0, 0, 0, 0, 0, 3, 14, 'h44, 13, 'h33, 0,      1, 4, 1, 6, 'h60, 'h61);
    add(0, 0, 0, 0, 0, 0, 0, 3, 12, 'h22, 11, 'h11, 0,      1, 4, 1, 6, 'h60, 'h61);
    // Release; target 5 is dispatched again while full and an entry leaves: still dropped
    add(0, 1, 5, 0, 0, 'h55, 'h55, 0, 0, 0, 0, 0, 1,        0, 3, 1, 1, 'h11, 'h101);
    idle(1,                                                  0, 2, 1, 2, 'h22, 'h102);
    idle(1,                                                  0, 1, 1, 3, 'h33, 'h33);
    idle(1,                                                  0, 0, 1, 4, 'h44, 'h33);
    idle(1,                                                  0, 0, 0, 0, 0, 0);
    // Backpressure with two ready entries; dispatch and issue in one cycle keeps count
    add(0, 1, 8, 0, 0, 'h80, 'h81, 0, 0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0);
    add(0, 1, 9, 0, 0, 'h90, 'h91, 0, 0, 0, 0, 0, 0,        0, 1, 1, 8, 'h80, 'h81);
    for (int i = 0; i < 4; i++) idle(0,                      0, 1, 1, 8, 'h80, 'h81);
    idle(1,                                                  0, 0, 1, 9, 'h90, 'h91);
    idle(1,                                                  0, 0, 0, 0, 0, 0);
    // Age beats slot index: target 3 reuses slot 0 but is younger than target 2 in slot 1
    add(0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1,              0, 1, 0, 0, 0, 0);
    add(0, 1, 2, 11, 0, 0, 'h202, 0, 0, 0, 0, 0, 1,         0, 1, 1, 1, 1, 1);
    add(0, 1, 3, 12, 0, 0, 'h203, 0, 0, 0, 0, 0, 1,         0, 2, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 3, 12, 'hC, 11, 'hB, 1,        0, 2, 0, 0, 0, 0);
    idle(1,                                                  0, 1, 1, 2, 'hB, 'h202);
    idle(1,                                                  0, 0, 1, 3, 'hC, 'h203);
    idle(1,                                                  0, 0, 0, 0, 0, 0);
    // Build 3 entries with a held output, then flush alongside a dispatch and a broadcast
    add(0, 1, 10, 15, 0, 0, 'h30A, 0, 0, 0, 0, 0, 0,        0, 1, 0, 0, 0, 0);
    add(0, 1, 11, 15, 0, 0, 'h30B, 0, 0, 0, 0, 0, 0,        0, 2, 0, 0, 0, 0);
    add(0, 1, 12, 0, 0, 'hC0, 'hC1, 0, 0, 0, 0, 0, 0,       0, 3, 0, 0, 0, 0);
    add(0, 1, 13, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 3, 1, 12, 'hC0, 'hC1);
    add(1, 1, 14, 0, 0, 'hE0, 'hE1, 1, 15, 'hF, 0, 0, 0,    0, 0, 0, 0, 0, 0);

    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      v = vecs[i];
      drive(v);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d full", i), 32'(bus.full), v.ef);
      chk($sformatf("row%0d count", i), 32'(bus.count), v.ec);
      chk($sformatf("row%0d out_valid", i), 32'(bus.out_valid), v.ev);
      if (v.ev != 0) begin
        et = v.et;
        chk($sformatf("row%0d out_target", i), 32'(bus.out_target), v.et);
        chk($sformatf("row%0d out_op", i), 32'(bus.out_op), 32'({2'b10, et[TAG_W-1:0]}));
        chk($sformatf("row%0d out_val1", i), bus.out_val1, v.v1 == 0 ? v.e1 : v.e1);
        chk($sformatf("row%0d out_val2", i), bus.out_val2, v.e2);
      end
    end

    // Flush clears the output registers exactly like reset
    chk("flush out_target", 32'(bus.out_target), 0);
    chk("flush out_op", 32'(bus.out_op), 0);
    chk("flush out_val1", bus.out_val1, 0);
    chk("flush out_val2", bus.out_val2, 0);

    // Nothing flushed may ever issue, even if tag 15 is broadcast afterwards
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v = '{0, 0, 0, 0, 0, 0, 0, 1, 15, 'hF, 0, 0, 1, 0, 0, 0, 0, 0, 0};
      drive(v);
      @(posedge clk);
      #1;
      chk($sformatf("post-flush%0d out_valid", i), 32'(bus.out_valid), 0);
      chk($sformatf("post-flush%0d count", i), 32'(bus.count), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
